// File: rtl/scl_clock_gen.sv
// scl_clock_gen: run-time programmable SCL generator with phase strobes, clock-stretch timeout and graceful stop
module scl_clock_gen #(
  parameter int                 P_CNT_W       = 8,
  parameter int                 P_DIV_DEFAULT = 40,
  parameter int                 P_DIV_MIN     = 20,
  parameter int                 P_CHK         = 3,
  parameter int                 P_TMO_W       = 16,
  parameter logic [P_TMO_W-1:0] P_TMO_MAX     = 16'd140
) (
  input  logic               I_CLK_4M,
  input  logic               I_rst_n,
  input  logic               I_SCL_en,
  input  logic [P_CNT_W-1:0] I_div,
  input  logic               I_div_ld,
  input  logic               I_SCL_in,
  output logic               O_SCL_POS,
  output logic               O_SCL_HIG,
  output logic               O_SCL_NEG,
  output logic               O_SCL_LOW,
  output logic               O_SCL,
  output logic               O_stretch,
  output logic               O_timeout,
  output logic               O_busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STRETCH, S_DRAIN} state_t;
  localparam logic [P_CNT_W-1:0] L_DEF = P_CNT_W'(P_DIV_DEFAULT);
  localparam logic [P_CNT_W-1:0] L_MIN = P_CNT_W'(P_DIV_MIN);
  localparam logic [P_CNT_W-1:0] L_CHK = P_CNT_W'(P_CHK);
  state_t             r_state, w_state_nxt;
  logic [P_CNT_W-1:0] r_cnt, w_cnt_nxt, r_pend, r_act, w_h, w_q;
  logic [P_TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic               r_sync1, r_scl_s, r_timeout, w_timeout_nxt;
  logic               w_act_ld, w_live, w_wrap, w_stall;
  assign w_h     = r_act >> 1;
  assign w_q     = r_act >> 2;
  assign w_live  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_wrap  = r_cnt == r_act - 1'b1;
  assign w_stall = (r_cnt == L_CHK) && !r_scl_s;
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_timeout_nxt = r_timeout;
    w_act_ld      = 1'b0;
    case (r_state)
      S_IDLE: if (I_SCL_en) begin
        w_state_nxt   = S_RUN;
        w_cnt_nxt     = '0;
        w_act_ld      = 1'b1;
        w_timeout_nxt = 1'b0;
      end
      S_RUN, S_DRAIN: if (w_stall) begin
        w_state_nxt = S_STRETCH;
        w_tmo_nxt   = '0;
      end else begin
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
        w_act_ld    = w_wrap;
        w_state_nxt = I_SCL_en ? S_RUN : (r_state == S_DRAIN && w_wrap) ? S_IDLE : S_DRAIN;
      end
      S_STRETCH: if (r_scl_s) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = r_cnt + 1'b1;
      end else if (r_tmo + 1'b1 == P_TMO_MAX) begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_timeout_nxt = 1'b1;
      end else begin
        w_tmo_nxt = r_tmo + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge I_CLK_4M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend    <= L_DEF;
      r_act     <= L_DEF;
      r_sync1   <= 1'b1;
      r_scl_s   <= 1'b1;
      r_tmo     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_timeout <= w_timeout_nxt;
      r_sync1   <= I_SCL_in;
      r_scl_s   <= r_sync1;
      if (I_div_ld) r_pend <= (I_div < L_MIN) ? L_MIN : I_div;
      // a load coinciding with a wrap is deferred one period: active sees the old pending
      if (w_act_ld) r_act <= r_pend;
    end
  end
  assign O_SCL_POS = w_live && (r_cnt == P_CNT_W'(1));
  assign O_SCL_HIG = w_live && (r_cnt == w_q - 1'b1);
  assign O_SCL_NEG = w_live && (r_cnt == w_h + 1'b1);
  assign O_SCL_LOW = w_live && (r_cnt == w_q + w_h - 1'b1);
  assign O_SCL     = !w_live || (r_cnt <= w_h - 1'b1);
  assign O_stretch = r_state == S_STRETCH;
  assign O_timeout = r_timeout;
  assign O_busy    = r_state != S_IDLE;
endmodule

// File: tb/tb_scl_clock_gen.sv
// tb_scl_clock_gen: table-driven period checks plus hand sequences for stretch, timeout and async reset
module tb_scl_clock_gen;
  logic       I_CLK_4M = 1'b0, I_rst_n = 1'b0, I_SCL_en = 1'b0, I_div_ld = 1'b0, I_SCL_in = 1'b1;
  logic [7:0] I_div = '0;
  logic       O_SCL_POS, O_SCL_HIG, O_SCL_NEG, O_SCL_LOW, O_SCL, O_stretch, O_timeout, O_busy;
  int         n_chk = 0, n_err = 0;
  typedef struct {int n; int hig; int neg; int low; int hi; int ld_at; int ld_val; int off_at; int on_at;} vec_t;
  vec_t tbl [14];
  always #5 I_CLK_4M = ~I_CLK_4M;
  scl_clock_gen dut (
    .I_CLK_4M(I_CLK_4M), .I_rst_n(I_rst_n), .I_SCL_en(I_SCL_en), .I_div(I_div), .I_div_ld(I_div_ld),
    .I_SCL_in(I_SCL_in), .O_SCL_POS(O_SCL_POS), .O_SCL_HIG(O_SCL_HIG), .O_SCL_NEG(O_SCL_NEG),
    .O_SCL_LOW(O_SCL_LOW), .O_SCL(O_SCL), .O_stretch(O_stretch), .O_timeout(O_timeout), .O_busy(O_busy)
  );
  function automatic logic [6:0] outs();
    return {O_SCL, O_SCL_POS, O_SCL_HIG, O_SCL_NEG, O_SCL_LOW, O_busy, O_stretch};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge I_CLK_4M);
    #1;
  endtask
  task automatic run_period(input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      check($sformatf("N%0d cnt%0d {scl,pos,hig,neg,low,busy,str}", v.n, k), outs(),
            {k < v.hi, k == 1, k == v.hig, k == v.neg, k == v.low, 1'b1, 1'b0});
      I_div_ld = (k == v.ld_at);
      if (k == v.ld_at) I_div = 8'(v.ld_val);
      if (k == v.off_at) I_SCL_en = 1'b0;
      if (k == v.on_at) I_SCL_en = 1'b1;
      tick();
    end
    I_div_ld = 1'b0;
  endtask
  task automatic wait_pos();
    int b = 0;
    while (!O_SCL_POS && b < 200) begin
      tick();
      b++;
    end
    check("pos strobe found", b < 200, 1);
  endtask
  initial begin
    int n_st, n_sb, n_lo, hig_i;
    tbl = '{
      '{40, 9, 21, 29, 20, -1,  0, -1, -1},
      '{40, 9, 21, 29, 20, 10, 20, -1, -1},
      '{20, 4, 11, 14, 10, -1,  0, -1, -1},
      '{20, 4, 11, 14, 10, 10,  5, -1, -1},
      '{20, 4, 11, 14, 10, -1,  0, -1, -1},
      '{20, 4, 11, 14, 10, 10, 60, -1, -1},
      '{60, 14, 31, 44, 30, 10, 41, -1, -1},
      '{41, 9, 21, 29, 20, -1,  0, -1, -1},
      '{41, 9, 21, 29, 20, 40, 20, -1, -1},
      '{41, 9, 21, 29, 20, -1,  0, -1, -1},
      '{20, 4, 11, 14, 10, 10, 40, -1, -1},
      '{40, 9, 21, 29, 20, -1,  0, 10, -1},
      '{40, 9, 21, 29, 20, -1,  0, 10, 30},
      '{40, 9, 21, 29, 20, -1,  0, -1, -1}
    };
    tick();
    check("reset outs", outs(), 7'b1000000);
    check("reset timeout", O_timeout, 0);
    #2 I_rst_n = 1'b1;
    I_SCL_en = 1'b1;
    tick();
    foreach (tbl[r]) begin
      run_period(tbl[r]);
      if (!I_SCL_en) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("drained idle %0d", k), outs(), 7'b1000000);
          tick();
        end
        I_SCL_en = 1'b1;
        tick();
      end
    end
    n_st = 0; n_sb = 0; n_lo = 0; hig_i = -1;
    for (int i = 0; i < 60; i++) begin
      if (O_stretch) begin
        n_st++;
        n_sb += O_SCL_POS + O_SCL_HIG + O_SCL_NEG + O_SCL_LOW;
        n_lo += !O_SCL;
      end
      if (O_SCL_HIG && hig_i < 0) hig_i = i;
      if (i == 0) I_SCL_in = 1'b0;
      if (i == 50) I_SCL_in = 1'b1;
      tick();
    end
    check("stretch cycles", n_st, 49);
    check("strobes during stretch", n_sb, 0);
    check("scl low during stretch", n_lo, 0);
    check("hig after resume", hig_i, 58);
    check("no timeout on short stretch", O_timeout, 0);
    wait_pos();
    I_SCL_in = 1'b0;
    I_SCL_en = 1'b0;
    n_st = 0;
    for (int j = 0; j < 150; j++) begin
      n_st += O_stretch;
      if (j == 143) check("timeout {busy,tmo,scl}", {O_busy, O_timeout, O_SCL}, 3'b011);
      tick();
    end
    check("stretch cycles before timeout", n_st, 140);
    I_SCL_in = 1'b1;
    repeat (3) tick();
    check("timeout sticky {busy,tmo,scl}", {O_busy, O_timeout, O_SCL}, 3'b011);
    I_SCL_en = 1'b1;
    tick();
    check("restart clears timeout", {O_busy, O_timeout, O_SCL}, 3'b101);
    tick();
    check("restart pos", O_SCL_POS, 1);
    I_div = 8'd20;
    I_div_ld = 1'b1;
    tick();
    I_div_ld = 1'b0;
    repeat (23) tick();
    check("scl low at cnt25", {O_SCL, O_busy}, 2'b01);
    #3 I_rst_n = 1'b0;
    #1 check("async reset outs", outs(), 7'b1000000);
    check("async reset timeout", O_timeout, 0);
    tick();
    check("held reset outs", outs(), 7'b1000000);
    #2 I_rst_n = 1'b1;
    tick();
    run_period(tbl[0]);
    run_period(tbl[0]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
